register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised next-generation register file: configurable data width, register count and number of read ports.
- Register 0 is hardwired to zero.
- Adds a handshaked debug-scan engine that walks every register in order, so an FPGA wrapper or bench can dump the full architectural state without disturbing normal reads.
- Sits in the datapath as the general-purpose register file; the scan port feeds board-level debug logic.

Parameters:
- DATA_W, 32, bits per register.
- NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS).
- NREAD, 2, number of independent combinational read ports (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- WEN  in  1  write enable.
- wsel  in  AW  write register index.
- wdat  in  DATA_W  write data.
- rsel  in  NREAD*AW  packed read indices; port i uses bits [i*AW +: AW].
- rdat  out  NREAD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W].
- scan_start  in  1  request a full register dump.
- scan_ready  in  1  consumer accepts the current scan beat.
- scan_valid  out  1  scan_idx/scan_dat hold a valid beat.
- scan_idx  out  AW  index of the register being presented.
- scan_dat  out  DATA_W  contents of register scan_idx.
- scan_busy  out  1  scan engine not IDLE.
- scan_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock CLK. Reset nRST is synchronous and active-low, sampled on the rising edge.
- Reset: all registers = 0; FSM = IDLE; scan_valid=0, scan_busy=0, scan_done=0, scan_idx=0. rdat and scan_dat are combinational and therefore read 0 after reset.
- Write:
  - On a rising edge with WEN=1 and wsel!=0, reg[wsel] <= wdat.
  - Writes to index 0 are discarded; reg[0] always reads 0.
- Read:
  - rdat[i] = reg[rsel[i]], combinational, zero latency.
  - Any number of ports may select the same index.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE: scan_start=1 -> SCAN with scan_idx=0. Otherwise stay in IDLE.
  - SCAN:
    - scan_valid=1; scan_dat = reg[scan_idx] (stored value, no bypass).
    - scan_ready=1 and scan_idx!=NREGS-1 -> scan_idx+1.
    - scan_ready=1 and scan_idx==NREGS-1 -> DONE.
    - scan_ready=0 -> hold scan_idx and scan_valid.
  - DONE: scan_done=1 and scan_valid=0 for exactly one cycle -> IDLE; scan_idx returns to 0.
  - scan_busy=1 in SCAN and DONE.
- scan_start while busy: ignored; no restart or queueing.
- Write during scan:
  - A stalled beat (scan_ready=0) must track the current contents, so scan_dat changes the cycle after a write to scan_idx.
  - Already-accepted registers are not revisited.
- Reset mid-scan: reset takes priority. FSM -> IDLE and registers cleared in the same edge; no scan_done pulse.
- Index arithmetic: scan_idx is AW bits and never wraps, because the terminal compare is NREGS-1.
- Simultaneous WEN and a read of the same index: result depends on the optional feature below.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: for each port i, if WEN=1, wsel!=0 and wsel==rsel[i], then rdat[i]=wdat in the same cycle (write-to-read forwarding). The scan port is never bypassed.
- Undefined: rdat[i] returns the stored value; the new value is visible the cycle after the write edge.

Decomposition:
- Package regfile_pkg:
  - localparams for default DATA_W/NREGS.
  - scan_state_t enum {IDLE, SCAN, DONE}.
  - Parametrised helpers for word and index types.
- Sub-module regfile_scan_fsm:
  - Owns the state, scan_idx, scan_valid, scan_busy and scan_done.
  - Supplies scan_idx to the parent's read mux.
- Register storage and read/bypass muxing stay in register_file_mp.

Test Plan:
- Reset then read: nRST=0 for 2 cycles, all rsel swept 0..31 -> every rdat=0; scan_busy=0.
- Write/read, r0 immune:
  - WEN=1, wsel=5, wdat=32'hDEADBEEF; next cycle rsel0=5, rsel1=5 -> both rdat=DEADBEEF.
  - wsel=0, wdat=32'hFFFFFFFF -> rdat for rsel=0 stays 0.
- Bypass: WEN=1, wsel=7, wdat=32'h12345678, rsel0=7 in the same cycle.
  - With REGFILE_BYPASS_EN -> rdat0=12345678 that cycle.
  - Without -> old value (0) that cycle, 12345678 the next.
- Full scan with back-pressure:
  - Preload reg[i]=i*3; pulse scan_start; toggle scan_ready 1,0,1,...
  - 32 accepted beats with scan_idx 0..31 and scan_dat=i*3 (beat 0 = 0).
  - scan_done pulses exactly once, 1 cycle after the beat-31 accept; scan_start during the scan is ignored.
- Write during stalled beat: scan stalled at idx 4 (scan_ready=0); write reg[4]=32'hA5A5A5A5 -> next cycle scan_dat=A5A5A5A5; on accept, advances to idx 5.
- Reset mid-scan: at idx 10 assert nRST=0 for one edge -> scan_busy=0, scan_valid=0, no scan_done; reg[10] then reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared defaults, scan FSM state encoding and index-width helper.
// Revision: 1.0
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NREAD  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    function automatic int idx_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module  : register_file_mp_if
// Purpose : Write/read/scan bus of the multi-port register file.
// Revision: 1.0
// ============================================================================
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2
);
    import regfile_pkg::*;

    localparam int AW = idx_w(NREGS);

    logic                    WEN;
    logic [AW-1:0]           wsel;
    logic [DATA_W-1:0]       wdat;
    logic [NREAD*AW-1:0]     rsel;
    logic [NREAD*DATA_W-1:0] rdat;
    logic                    scan_start;
    logic                    scan_ready;
    logic                    scan_valid;
    logic [AW-1:0]           scan_idx;
    logic [DATA_W-1:0]       scan_dat;
    logic                    scan_busy;
    logic                    scan_done;

    modport master (
        output WEN, wsel, wdat, rsel, scan_start, scan_ready,
        input  rdat, scan_valid, scan_idx, scan_dat, scan_busy, scan_done
    );

    modport slave (
        input  WEN, wsel, wdat, rsel, scan_start, scan_ready,
        output rdat, scan_valid, scan_idx, scan_dat, scan_busy, scan_done
    );

endinterface
`default_nettype wire

// File: rtl/regfile_scan_fsm.sv
`default_nettype none
// ============================================================================
// Module  : regfile_scan_fsm
// Purpose : Handshaked walker presenting register indices 0..NREGS-1 in order.
// Revision: 1.0
// ============================================================================
module regfile_scan_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = idx_w(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          nRST,
    input  wire logic          i_start,
    input  wire logic          i_ready,
    output logic               o_valid,
    output logic [AW-1:0]      o_idx,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                // Terminal compare on the last index means the counter never wraps.
                if (i_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_valid = (r_state == SCAN);
    assign o_busy  = (r_state != IDLE);
    assign o_done  = (r_state == DONE);
    assign o_idx   = r_idx;

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : register_file_mp
// Purpose : Multi-read-port register file (r0 = 0) with debug scan engine.
//           Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision: 1.0
// ============================================================================
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = DEF_NREAD
) (
    input  wire logic         CLK,
    input  wire logic         nRST,
    register_file_mp_if.slave bus
);

    localparam int AW = idx_w(NREGS);

    logic [DATA_W-1:0]       r_regs [NREGS];
    logic [AW-1:0]           w_scan_idx;
    logic [NREAD*DATA_W-1:0] w_rdat;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.WEN && (bus.wsel != '0)) begin
            r_regs[bus.wsel] <= bus.wdat;
        end
    end

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < NREAD; i++) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.WEN && (bus.wsel != '0) && (bus.wsel == bus.rsel[i*AW +: AW])) begin
                w_rdat[i*DATA_W +: DATA_W] = bus.wdat;
            end else begin
                w_rdat[i*DATA_W +: DATA_W] = r_regs[bus.rsel[i*AW +: AW]];
            end
`else
            w_rdat[i*DATA_W +: DATA_W] = r_regs[bus.rsel[i*AW +: AW]];
`endif
        end
    end

    assign bus.rdat = w_rdat;

    regfile_scan_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scan (
        .clk     (CLK),
        .nRST    (nRST),
        .i_start (bus.scan_start),
        .i_ready (bus.scan_ready),
        .o_valid (bus.scan_valid),
        .o_idx   (w_scan_idx),
        .o_busy  (bus.scan_busy),
        .o_done  (bus.scan_done)
    );

    // Scan reads stored state only, so a stalled beat follows writes one cycle later.
    assign bus.scan_idx = w_scan_idx;
    assign bus.scan_dat = r_regs[w_scan_idx];

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_file_mp
// Purpose : Scoreboard bench for register_file_mp (reads, r0, bypass, scan).
// Revision: 1.0
// ============================================================================
module tb_register_file_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 2;
    localparam int AW = 5;

    localparam int K_RD0 = 0, K_RD1 = 1, K_BUSY = 2, K_VALID = 3,
                   K_SDAT = 4, K_SIDX = 5, K_DONECNT = 6;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] dat;
    } beat_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    register_file_mp_if #(.DATA_W(DW), .NREGS(NR), .NREAD(NP)) bus();

    register_file_mp #(.DATA_W(DW), .NREGS(NR), .NREAD(NP)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    chk_t  chk_q [$];
    beat_t beat_q[$];
    int    errors   = 0;
    int    checks   = 0;
    int    done_cnt = 0;
    bit    prev_last = 1'b0;

    task automatic expect_now(input int kind, input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = kind; c.exp = e; c.name = nm;
        chk_q.push_back(c);
    endtask

    task automatic push_beat(input int idx, input logic [31:0] d);
        beat_t b;
        b.idx = AW'(idx); b.dat = d;
        beat_q.push_back(b);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD0:     return bus.rdat[31:0];
            K_RD1:     return bus.rdat[63:32];
            K_BUSY:    return {31'b0, bus.scan_busy};
            K_VALID:   return {31'b0, bus.scan_valid};
            K_SDAT:    return bus.scan_dat;
            K_SIDX:    return {27'b0, bus.scan_idx};
            K_DONECNT: return done_cnt;
            default:   return 32'hXXXX_XXXX;
        endcase
    endfunction

    // Monitor: drains immediate checks and scores every accepted scan beat.
    always @(negedge CLK) begin : mon
        chk_t        c;
        beat_t       b;
        logic [31:0] a;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            a = actual(c.kind);
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
            end
        end
        if (bus.scan_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (!prev_last) begin
                errors++;
                $display("FAIL done_timing: got done without prior last accept (0) expected 1");
            end
        end
        prev_last = 1'b0;
        if (bus.scan_valid === 1'b1 && bus.scan_ready === 1'b1) begin
            checks++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL scan_beat: got unexpected beat idx %0d expected none", bus.scan_idx);
            end else begin
                b = beat_q.pop_front();
                if (bus.scan_idx !== b.idx || bus.scan_dat !== b.dat) begin
                    errors++;
                    $display("FAIL scan_beat: got idx %0d dat %h expected idx %0d dat %h",
                             bus.scan_idx, bus.scan_dat, b.idx, b.dat);
                end
            end
            prev_last = (bus.scan_idx == AW'(NR - 1));
        end
    end

    task automatic run_scan(input bit toggle, input bit inject_start);
        bit finished = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            bus.scan_ready = toggle ? (k % 2 == 0) : 1'b1;
            bus.scan_start = (inject_start && k == 9);
            if (beat_q.size() == 0 && !bus.scan_busy) begin
                finished = 1'b1;
                break;
            end
        end
        bus.scan_ready = 1'b0;
        bus.scan_start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: got %0d beats outstanding expected 0", beat_q.size());
            beat_q.delete();
        end
    endtask

    initial begin
        bus.WEN = 1'b0; bus.wsel = '0; bus.wdat = '0; bus.rsel = '0;
        bus.scan_start = 1'b0; bus.scan_ready = 1'b0;

        // Reset held for two edges, then sweep every index on both ports.
        step(); step();
        nRST = 1'b1;
        for (int i = 0; i < NR; i++) begin
            step();
            bus.rsel = {AW'(NR - 1 - i), AW'(i)};
            expect_now(K_RD0, 32'h0, "reset_rd0");
            expect_now(K_RD1, 32'h0, "reset_rd1");
            if (i == 0) expect_now(K_BUSY, 32'h0, "reset_busy");
        end

        step();
        bus.WEN = 1'b1; bus.wsel = 5'd5; bus.wdat = 32'hDEADBEEF;
        step();
        bus.WEN = 1'b0; bus.rsel = {5'd5, 5'd5};
        expect_now(K_RD0, 32'hDEADBEEF, "wr5_rd0");
        expect_now(K_RD1, 32'hDEADBEEF, "wr5_rd1");
        step();
        bus.WEN = 1'b1; bus.wsel = 5'd0; bus.wdat = 32'hFFFFFFFF;
        step();
        bus.WEN = 1'b0; bus.rsel = {5'd5, 5'd0};
        expect_now(K_RD0, 32'h0, "r0_immune");
        expect_now(K_RD1, 32'hDEADBEEF, "r5_keep");

        step();
        bus.WEN = 1'b1; bus.wsel = 5'd7; bus.wdat = 32'h12345678; bus.rsel = {5'd0, 5'd7};
`ifdef REGFILE_BYPASS_EN
        expect_now(K_RD0, 32'h12345678, "bypass_same_cycle");
`else
        expect_now(K_RD0, 32'h0, "no_bypass_same_cycle");
`endif
        expect_now(K_RD1, 32'h0, "bypass_r0");
        step();
        bus.WEN = 1'b0;
        expect_now(K_RD0, 32'h12345678, "bypass_next_cycle");

        for (int i = 1; i < NR; i++) begin
            step();
            bus.WEN = 1'b1; bus.wsel = AW'(i); bus.wdat = 32'(i * 3);
        end
        step();
        bus.WEN = 1'b0;

        // Full scan with alternating back-pressure and a stray start mid-scan.
        for (int i = 0; i < NR; i++) push_beat(i, 32'(i * 3));
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        expect_now(K_BUSY, 32'h1, "scan_busy");
        run_scan(1'b1, 1'b1);
        expect_now(K_DONECNT, 32'd1, "done_once");
        expect_now(K_BUSY, 32'h0, "scan_idle");

        // Stall at index 4 and overwrite it.
        for (int i = 0; i < NR; i++) push_beat(i, (i == 4) ? 32'hA5A5A5A5 : 32'(i * 3));
        step();
        bus.scan_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.scan_start = 1'b0;
            bus.scan_ready = 1'b1;
        end
        step();
        bus.scan_ready = 1'b0;
        bus.WEN = 1'b1; bus.wsel = 5'd4; bus.wdat = 32'hA5A5A5A5;
        expect_now(K_SIDX, 32'd4, "stall_idx");
        expect_now(K_SDAT, 32'd12, "stall_old_dat");
        expect_now(K_VALID, 32'h1, "stall_valid");
        step();
        bus.WEN = 1'b0;
        expect_now(K_SDAT, 32'hA5A5A5A5, "stall_new_dat");
        expect_now(K_SIDX, 32'd4, "stall_idx_hold");
        run_scan(1'b1, 1'b0);
        expect_now(K_DONECNT, 32'd2, "done_twice");

        // Reset while the scan sits at index 10.
        for (int i = 0; i < 10; i++) push_beat(i, (i == 4) ? 32'hA5A5A5A5 : 32'(i * 3));
        step();
        bus.scan_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            bus.scan_start = 1'b0;
            bus.scan_ready = 1'b1;
        end
        step();
        bus.scan_ready = 1'b0;
        nRST = 1'b0;
        expect_now(K_SIDX, 32'd10, "pre_reset_idx");
        expect_now(K_VALID, 32'h1, "pre_reset_valid");
        step();
        nRST = 1'b1;
        bus.rsel = {5'd4, 5'd10};
        expect_now(K_BUSY, 32'h0, "midreset_busy");
        expect_now(K_VALID, 32'h0, "midreset_valid");
        expect_now(K_RD0, 32'h0, "midreset_r10");
        expect_now(K_RD1, 32'h0, "midreset_r4");
        step();
        step();
        expect_now(K_DONECNT, 32'd2, "midreset_no_done");
        checks++;
        if (beat_q.size() != 0) begin
            errors++;
            $display("FAIL beats_left: got %0d expected 0", beat_q.size());
        end
        step();
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
